if_fetch_stage: RTL



---
 rtl/if_fetch_stage_if.sv | 25 ++
 rtl/if_fetch_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory request/response port.
// req/gnt issue handshake, in-order rvalid/rdata response.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch PC owner, single-outstanding imem port,
// 1-entry holding buffer for IF/ID stall, redirect kill.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            o_pc,
  output logic [31:0]            o_inst,
  output logic                   o_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic        r_run;
  logic        r_hb_vld;
  fetch_t      r_hb;

  logic        w_rsp;
  logic        w_to_hb;
  logic        w_req;
  logic        w_fire;
  logic [31:0] w_tgt;

  assign w_tgt = {i_redirect_pc[31:2], 2'b00};

  // a kept response arrives this cycle
  assign w_rsp = (r_state == S_WAIT) & imem.imem_rvalid;

  // the response lands in the holding buffer; no new issue then,
  // otherwise its reply could meet a full buffer under stall
  assign w_to_hb = w_rsp & o_valid & i_stall;

  assign w_req = r_run & ~i_redirect & ~r_hb_vld & ~w_to_hb &
                 ((r_state == S_IDLE) | w_rsp);

  assign w_fire = w_req & imem.imem_gnt;

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  // fetch PC, request PC and outstanding-request state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_run    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (i_redirect) begin
        r_pc <= w_tgt;
      end else if (w_fire) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_fire) begin
        r_req_pc <= r_pc;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_fire) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_redirect) begin
            r_state <= imem.imem_rvalid ? S_IDLE : S_DROP;
          end else if (imem.imem_rvalid) begin
            r_state <= w_fire ? S_WAIT : S_IDLE;
          end
        end
        S_DROP: begin
          if (imem.imem_rvalid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // IF/ID outputs and holding buffer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc     <= '0;
      o_inst   <= NOP;
      o_valid  <= 1'b0;
      r_hb_vld <= 1'b0;
      r_hb     <= '0;
    end else if (i_redirect) begin
      o_valid  <= 1'b0;
      o_inst   <= NOP;
      r_hb_vld <= 1'b0;
    end else if (w_rsp) begin
      if (!o_valid || !i_stall) begin
        o_pc    <= r_req_pc;
        o_inst  <= imem.imem_rdata;
        o_valid <= 1'b1;
      end else begin
        r_hb_vld <= 1'b1;
        r_hb     <= '{pc: r_req_pc, inst: imem.imem_rdata};
      end
    end else if (!i_stall) begin
      if (r_hb_vld) begin
        o_pc     <= r_hb.pc;
        o_inst   <= r_hb.inst;
        o_valid  <= 1'b1;
        r_hb_vld <= 1'b0;
      end else begin
        o_valid <= 1'b0;
        o_inst  <= NOP;
      end
    end
  end

endmodule
